// File: rtl/hdmi_line_prefetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_line_prefetch_if
//  Description : Bundle of the signals between the line prefetcher, the HDMI
//                timing generator and the DMA/memory fill port.
//                slave  modport : the prefetcher itself.
//                master modport : the environment that drives the prefetcher
//                                 (timing generator and memory port).
//  Signals     : pixelEnable, requestPixel, pixelIndex[10:0], newScreen,
//                nextLine, timHSync, timVSync     - generator timing inputs
//                fetchRequest, fetchLine[9:0], fetchAck,
//                fillValid, fillData[15:0]        - memory fetch/fill port
//                redOut[4:0], greenOut[5:0], blueOut[4:0],
//                hSyncOut, vSyncOut, activeOut    - to the generator
//                underrun                         - sticky status
//  Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_line_prefetch_if;
    // Generator timing side
    logic        pixelEnable;
    logic        requestPixel;
    logic [10:0] pixelIndex;
    logic        newScreen;
    logic        nextLine;
    logic        timHSync;
    logic        timVSync;
    // Memory fetch / fill side
    logic        fetchRequest;
    logic [9:0]  fetchLine;
    logic        fetchAck;
    logic        fillValid;
    logic [15:0] fillData;
    // Generator pixel inputs
    logic [4:0]  redOut;
    logic [5:0]  greenOut;
    logic [4:0]  blueOut;
    logic        hSyncOut;
    logic        vSyncOut;
    logic        activeOut;
    logic        underrun;

    modport slave (
        input  pixelEnable, requestPixel, pixelIndex, newScreen, nextLine,
               timHSync, timVSync, fetchAck, fillValid, fillData,
        output fetchRequest, fetchLine, redOut, greenOut, blueOut,
               hSyncOut, vSyncOut, activeOut, underrun
    );

    modport master (
        output pixelEnable, requestPixel, pixelIndex, newScreen, nextLine,
               timHSync, timVSync, fetchAck, fillValid, fillData,
        input  fetchRequest, fetchLine, redOut, greenOut, blueOut,
               hSyncOut, vSyncOut, activeOut, underrun
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_line_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_line_prefetch
//  Description : Upstream feeder for the 720p HDMI timing generator. Fetches
//                video lines from a DMA/memory port into a ping-pong line
//                buffer (2 x PIXELS_PER_LINE x RGB565) and replays them in
//                step with the generator, with a 2-pixelEnable read latency
//                applied equally to colour, syncs and active.
//  Ports       : pixelClkX2   in  clock, 2x pixel rate
//                reset        in  synchronous, active-high
//                prefetch_io  slave modport of hdmi_line_prefetch_if
//                             (timing inputs, fetch/fill port, pixel outputs,
//                             sticky underrun)
//  Options     : LINE_DOUBLE_EN - half-resolution source (640x360) is
//                upscaled: half-length fills, half the lines, each pixel and
//                each line shown twice.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_line_prefetch #(
    parameter int PIXELS_PER_LINE = 1280,
    parameter int LINES           = 720
) (
    input  wire logic            pixelClkX2,
    input  wire logic            reset,
    hdmi_line_prefetch_if.slave  prefetch_io
);

`ifdef LINE_DOUBLE_EN
    localparam int c_FILL_WORDS  = PIXELS_PER_LINE / 2;
    localparam int c_FETCH_LINES = LINES / 2;
`else
    localparam int c_FILL_WORDS  = PIXELS_PER_LINE;
    localparam int c_FETCH_LINES = LINES;
`endif

    localparam logic [10:0] c_LAST_WORD   = 11'(c_FILL_WORDS - 1);
    localparam logic [10:0] c_FETCH_LIMIT = 11'(c_FETCH_LINES);
    localparam logic [11:0] c_PIX_LIMIT   = 12'(PIXELS_PER_LINE);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_FILL = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [10:0] nextFetch_q, nextFetch_d;
    logic [1:0]  full_q, full_d;
    logic        readBuf_q, readBuf_d;
    logic        fetchEnable_q, fetchEnable_d;
    logic        discard_q, discard_d;
    logic        underrun_q, underrun_d;
`ifdef LINE_DOUBLE_EN
    logic        parity_q, parity_d;
`endif

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic        w_newScreen;
    logic        w_nextLine;
    logic        w_release;
    logic        w_fillWrite;
    logic        w_fillDone;
    logic        w_fillBuf;
    logic        w_hit;
    logic        w_start;

    // newScreen wins over a nextLine sampled on the same pixel.
    assign w_newScreen = prefetch_io.pixelEnable & prefetch_io.newScreen;
    assign w_nextLine  = prefetch_io.pixelEnable & prefetch_io.nextLine & ~prefetch_io.newScreen;

`ifdef LINE_DOUBLE_EN
    // Each source line is shown twice: only every second nextLine frees it.
    assign w_release = w_nextLine & parity_q;
`else
    assign w_release = w_nextLine;
`endif

    assign w_fillBuf   = nextFetch_q[0];
    assign w_fillWrite = (state_q == c_ST_FILL) & prefetch_io.fillValid & ~w_newScreen;
    assign w_fillDone  = w_fillWrite & (count_q == c_LAST_WORD);

    // The reader is moving onto the buffer that a fetch (requested or
    // filling) is targeting: that line arrives too late to be shown.
    assign w_hit = w_release & (state_q != c_ST_IDLE) & (w_fillBuf == ~readBuf_q);

    assign w_start = fetchEnable_q & (nextFetch_q < c_FETCH_LIMIT) & ~full_q[nextFetch_q[0]];

    // ------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pixelClkX2) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_start)              state_d = c_ST_REQ;
            c_ST_REQ:  if (prefetch_io.fetchAck) state_d = c_ST_FILL;
            c_ST_FILL: if (w_fillDone)           state_d = c_ST_IDLE;
            default:                             state_d = c_ST_IDLE;
        endcase
        if (w_newScreen) begin
            state_d = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        prefetch_io.fetchRequest = (state_q == c_ST_REQ);
        prefetch_io.fetchLine    = nextFetch_q[9:0];
    end

    // ------------------------------------------------------------------
    // Buffer bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        count_d       = count_q;
        nextFetch_d   = nextFetch_q;
        full_d        = full_q;
        readBuf_d     = readBuf_q;
        fetchEnable_d = fetchEnable_q;
        discard_d     = discard_q;
        underrun_d    = underrun_q;
`ifdef LINE_DOUBLE_EN
        parity_d      = parity_q ^ w_nextLine;
`endif

        if ((state_q == c_ST_REQ) && prefetch_io.fetchAck) begin
            count_d = 11'd0;
        end else if (w_fillWrite) begin
            count_d = count_q + 11'd1;
        end

        // A hit in the completing cycle also counts as a discard.
        if (w_fillDone) begin
            nextFetch_d = nextFetch_q + 11'd1;
            discard_d   = 1'b0;
            if (!(discard_q || w_hit)) begin
                full_d[w_fillBuf] = 1'b1;
            end
        end else if (w_hit) begin
            discard_d = 1'b1;
        end

        // Release is applied after completion so that both take effect on
        // different buffers; on the same buffer the release wins.
        if (w_release) begin
            full_d[readBuf_q] = 1'b0;
            readBuf_d         = ~readBuf_q;
            if (!full_q[~readBuf_q]) begin
                underrun_d = 1'b1;
            end
        end

        if (w_newScreen) begin
            count_d       = 11'd0;
            nextFetch_d   = 11'd0;
            full_d        = 2'b00;
            readBuf_d     = 1'b0;
            fetchEnable_d = 1'b1;
            discard_d     = 1'b0;
            underrun_d    = 1'b0;
`ifdef LINE_DOUBLE_EN
            parity_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge pixelClkX2) begin
        if (reset) begin
            count_q       <= 11'd0;
            nextFetch_q   <= 11'd0;
            full_q        <= 2'b00;
            readBuf_q     <= 1'b0;
            fetchEnable_q <= 1'b0;
            discard_q     <= 1'b0;
            underrun_q    <= 1'b0;
`ifdef LINE_DOUBLE_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            count_q       <= count_d;
            nextFetch_q   <= nextFetch_d;
            full_q        <= full_d;
            readBuf_q     <= readBuf_d;
            fetchEnable_q <= fetchEnable_d;
            discard_q     <= discard_d;
            underrun_q    <= underrun_d;
`ifdef LINE_DOUBLE_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign prefetch_io.underrun = underrun_q;

    // ------------------------------------------------------------------
    // Ping-pong line RAM: address = {buffer, word}. No reset so it maps
    // onto block RAM; unwritten words are never shown because colour is
    // gated by the buffer's full flag.
    // ------------------------------------------------------------------
    logic [15:0] lineRam_q [0:4095];
    logic [15:0] rdData_q;
    logic [10:0] w_rdIndex;

`ifdef LINE_DOUBLE_EN
    assign w_rdIndex = {1'b0, prefetch_io.pixelIndex[10:1]};
`else
    assign w_rdIndex = prefetch_io.pixelIndex;
`endif

    always_ff @(posedge pixelClkX2) begin
        if (w_fillWrite) begin
            lineRam_q[{w_fillBuf, count_q}] <= prefetch_io.fillData;
        end
    end

    always_ff @(posedge pixelClkX2) begin
        if (prefetch_io.pixelEnable) begin
            rdData_q <= lineRam_q[{readBuf_q, w_rdIndex}];
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 alongside the RAM read, stage 2 to outputs
    // ------------------------------------------------------------------
    logic s1Active_q, s1HSync_q, s1VSync_q, s1Show_q;
    logic [4:0] redOut_q;
    logic [5:0] greenOut_q;
    logic [4:0] blueOut_q;
    logic       hSyncOut_q, vSyncOut_q, activeOut_q;
    logic       w_inRange;

    assign w_inRange = ({1'b0, prefetch_io.pixelIndex} < c_PIX_LIMIT);

    always_ff @(posedge pixelClkX2) begin
        if (reset) begin
            s1Active_q  <= 1'b0;
            s1HSync_q   <= 1'b0;
            s1VSync_q   <= 1'b0;
            s1Show_q    <= 1'b0;
            redOut_q    <= 5'd0;
            greenOut_q  <= 6'd0;
            blueOut_q   <= 5'd0;
            hSyncOut_q  <= 1'b0;
            vSyncOut_q  <= 1'b0;
            activeOut_q <= 1'b0;
        end else if (prefetch_io.pixelEnable) begin
            s1Active_q  <= prefetch_io.requestPixel;
            s1HSync_q   <= prefetch_io.timHSync;
            s1VSync_q   <= prefetch_io.timVSync;
            s1Show_q    <= full_q[readBuf_q] & w_inRange;
            hSyncOut_q  <= s1HSync_q;
            vSyncOut_q  <= s1VSync_q;
            activeOut_q <= s1Active_q;
            if (s1Active_q && s1Show_q) begin
                redOut_q   <= rdData_q[15:11];
                greenOut_q <= rdData_q[10:5];
                blueOut_q  <= rdData_q[4:0];
            end else begin
                redOut_q   <= 5'd0;
                greenOut_q <= 6'd0;
                blueOut_q  <= 5'd0;
            end
        end
    end

    assign prefetch_io.redOut    = redOut_q;
    assign prefetch_io.greenOut  = greenOut_q;
    assign prefetch_io.blueOut   = blueOut_q;
    assign prefetch_io.hSyncOut  = hSyncOut_q;
    assign prefetch_io.vSyncOut  = vSyncOut_q;
    assign prefetch_io.activeOut = activeOut_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_line_prefetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hdmi_line_prefetch
//  Description : Self-checking bench for hdmi_line_prefetch. Random fill data,
//                pixel indices and syncs are checked against a line-level
//                model of the ping-pong buffers (which line sits in which
//                buffer, whether it is complete, what the reader shows).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_line_prefetch;

`ifdef LINE_DOUBLE_EN
    localparam int WORDS = 640;
    localparam int LF    = 360;
`else
    localparam int WORDS = 1280;
    localparam int LF    = 720;
`endif
    localparam int PPL = 1280;

    logic pixelClkX2 = 1'b0;
    logic reset      = 1'b1;

    hdmi_line_prefetch_if vif();

    hdmi_line_prefetch #(.PIXELS_PER_LINE(1280), .LINES(720)) dut (
        .pixelClkX2  (pixelClkX2),
        .reset       (reset),
        .prefetch_io (vif.slave)
    );

    always #5 pixelClkX2 = ~pixelClkX2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [15:0] mbuf [2][2048];
    bit          mfull [2];
    int          mrb, mnext, mpar, fcnt;
    bit          menable, mdisc, munder, filling;
    // Expected contents of the stage that drives the outputs next
    logic [15:0] e_col;
    bit          e_act, e_hs, e_vs;

    task automatic tick();
        @(posedge pixelClkX2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_req();
        return menable && (mnext < LF) && !mfull[mnext & 1] && !filling;
    endfunction

    task automatic chk_req();
        tick(); tick();
        chk("fetchRequest", {31'd0, vif.fetchRequest}, {31'd0, exp_req()});
        if (exp_req()) chk("fetchLine", {22'd0, vif.fetchLine}, mnext);
    endtask

    // One pixel: drive a pixelEnable cycle, check outputs, update the model.
    task automatic pe_cycle(input bit req, input int idx, input bit hs, input bit vs,
                            input bit ns, input bit nl);
        logic [15:0] ncol;
        int          addr;
        bit          rel, inprog;
        vif.pixelEnable  = 1'b1;
        vif.requestPixel = req;
        vif.pixelIndex   = idx[10:0];
        vif.timHSync     = hs;
        vif.timVSync     = vs;
        vif.newScreen    = ns;
        vif.nextLine     = nl;
`ifdef LINE_DOUBLE_EN
        addr = idx >> 1;
`else
        addr = idx;
`endif
        ncol = (req && mfull[mrb] && idx < PPL) ? mbuf[mrb][addr] : 16'd0;
        tick();
        chk("colour", {16'd0, vif.redOut, vif.greenOut, vif.blueOut}, {16'd0, e_col});
        chk("activeOut", {31'd0, vif.activeOut}, {31'd0, e_act});
        chk("syncs", {30'd0, vif.hSyncOut, vif.vSyncOut}, {30'd0, e_hs, e_vs});
        e_col = ncol; e_act = req; e_hs = hs; e_vs = vs;
        if (ns) begin
            mfull[0] = 0; mfull[1] = 0; mrb = 0; mnext = 0; mpar = 0;
            mdisc = 0; munder = 0; menable = 1; filling = 0;
        end else if (nl) begin
            rel = 1;
`ifdef LINE_DOUBLE_EN
            rel  = (mpar == 1);
            mpar = mpar ^ 1;
`endif
            if (rel) begin
                inprog = filling || exp_req();
                mfull[mrb] = 0;
                mrb = mrb ^ 1;
                if (!mfull[mrb]) munder = 1;
                if (inprog && ((mnext & 1) == mrb)) mdisc = 1;
            end
        end
        chk("underrun", {31'd0, vif.underrun}, {31'd0, munder});
        vif.pixelEnable = 1'b0;
        vif.newScreen   = 1'b0;
        vif.nextLine    = 1'b0;
        tick();
    endtask

    task automatic show_line(input int n);
        int idx, r;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(7);
            case (r)
                0: idx = PPL - 1;
                1: idx = PPL;
                2: idx = 0;
                3: idx = $urandom_range(2047);
                default: idx = $urandom_range(PPL - 1);
            endcase
            pe_cycle($urandom_range(3) != 0, idx, $urandom_range(1), $urandom_range(1), 0, 0);
        end
    endtask

    task automatic next_line();
`ifdef LINE_DOUBLE_EN
        pe_cycle(0, 0, 0, 0, 0, 1);
        show_line(6);
`endif
        pe_cycle(0, 0, 0, 0, 0, 1);
    endtask

    // Wait for a request, offer a stray word before the ack, then accept.
    task automatic req_ack();
        int w = 0;
        while (vif.fetchRequest !== 1'b1 && w < 64) begin
            tick();
            w++;
        end
        chk("req_seen", {31'd0, vif.fetchRequest}, 32'd1);
        chk("req_line", {22'd0, vif.fetchLine}, mnext);
        vif.fillValid = 1'b1; vif.fillData = 16'hDEAD; tick();
        vif.fillValid = 1'b0;
        vif.fetchAck  = 1'b1; tick();
        vif.fetchAck  = 1'b0;
        filling = 1; fcnt = 0;
    endtask

    // Send n words with random gaps; mode 1 sends pure red.
    task automatic fill_words(input int n, input bit mode);
        logic [15:0] d;
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(3) == 0) tick();
            d = mode ? 16'hF800 : 16'($urandom);
            vif.fillValid = 1'b1; vif.fillData = d; tick();
            vif.fillValid = 1'b0;
            mbuf[mnext & 1][fcnt] = d;
            fcnt++;
            if (fcnt == WORDS) begin
                if (!mdisc) mfull[mnext & 1] = 1;
                mdisc = 0; mnext++; filling = 0;
                vif.fillValid = 1'b1; vif.fillData = 16'hBEEF; tick();
                vif.fillValid = 1'b0;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.pixelEnable = 0; vif.requestPixel = 0; vif.pixelIndex = 0;
        vif.newScreen = 0; vif.nextLine = 0; vif.timHSync = 0; vif.timVSync = 0;
        vif.fetchAck = 0; vif.fillValid = 0; vif.fillData = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2048; i++) mbuf[b][i] = 16'd0;
        mfull[0] = 0; mfull[1] = 0; mrb = 0; mnext = 0; mpar = 0; fcnt = 0;
        menable = 0; mdisc = 0; munder = 0; filling = 0;
        e_col = 0; e_act = 0; e_hs = 0; e_vs = 0;

        // Reset state
        repeat (4) tick();
        chk("rst_pixels", {16'd0, vif.redOut, vif.greenOut, vif.blueOut}, 32'd0);
        chk("rst_ctrl", {27'd0, vif.hSyncOut, vif.vSyncOut, vif.activeOut, vif.underrun,
                         vif.fetchRequest}, 32'd0);
        chk("rst_fetchLine", {22'd0, vif.fetchLine}, 32'd0);
        reset = 1'b0;

        // No fetching before the first newScreen
        show_line(6);
        chk_req();

        // Start a frame, fetch lines 0 (pure red) and 1
        pe_cycle(0, 0, 0, 0, 1, 0);
        req_ack();
        fill_words(WORDS, 1);
        req_ack();
        fill_words(WORDS, 0);
        repeat (10) tick();
        chk_req();

        // Two pixelEnables of latency for colour, active and syncs
        pe_cycle(1, 0, 1, 0, 0, 0);
        pe_cycle(1, 7, 0, 1, 0, 0);
        chk("red_F800", {27'd0, vif.redOut}, 32'd31);
        chk("green_F800", {26'd0, vif.greenOut}, 32'd0);
        chk("blue_F800", {27'd0, vif.blueOut}, 32'd0);
        chk("active_lat", {31'd0, vif.activeOut}, 32'd1);
        chk("hsync_lat", {31'd0, vif.hSyncOut}, 32'd1);
        show_line(30);
        next_line();
        chk_req();

        // Line 2 arrives in time; line 3 is late -> underrun, shown black
        req_ack();
        fill_words(WORDS, 0);
        show_line(30);
        next_line();
        req_ack();
        fill_words(100, 0);
        show_line(20);
        next_line();
        chk("underrun_set", {31'd0, vif.underrun}, 32'd1);
        show_line(20);
        fill_words(WORDS - 100, 0);
        show_line(20);
        req_ack();
        fill_words(WORDS, 0);
        next_line();
        show_line(20);
        pe_cycle(0, 0, 0, 0, 1, 0);
        chk("underrun_clr", {31'd0, vif.underrun}, 32'd0);

        // newScreen in the middle of a fill restarts line 0 from word 0
        req_ack();
        fill_words(600, 0);
        pe_cycle(0, 0, 0, 0, 1, 0);
        req_ack();
        fill_words(WORDS, 0);
        req_ack();
        fill_words(WORDS, 0);
        show_line(30);
        next_line();
        show_line(30);
        chk_req();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
